// File: rtl/pmod_pkg.sv
// pmod_pkg: shared FSM state encoding and default parameters for the PMOD shift transmitter.
package pmod_pkg;
    localparam int CLKDIV_DEF = 6;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
endpackage

// File: rtl/pmod_tick_div.sv
// pmod_tick_div: CLKDIV down-counter restarted on each phase change; tick marks the phase's last cycle.
module pmod_tick_div
    import pmod_pkg::*;
#(
    parameter int CLKDIV = CLKDIV_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= (restart || cnt == 8'd0) ? 8'(CLKDIV - 1) : cnt - 8'd1;
    end
    assign tick = (cnt == 8'd0);
endmodule

// File: rtl/pmod_shift_tx.sv
// pmod_shift_tx: MSB-first serialiser for a PMOD shift/storage register pair.
// Define PMOD_SHIFT_TX_READBACK_EN to add the sdi daisy-chain return and rx_data.
module pmod_shift_tx
    import pmod_pkg::*;
#(
    parameter int CLKDIV = CLKDIV_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             sclk,
    output logic             sdo,
    output logic             latch,
    output logic             done
`ifdef PMOD_SHIFT_TX_READBACK_EN
    ,
    input  logic             sdi,
    output logic [WIDTH-1:0] rx_data
`endif
);
    state_t state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [5:0] bits, bits_n;
    logic tick, finish;

    pmod_tick_div #(.CLKDIV(CLKDIV)) u_div (
        .clk(clk),
        .reset_n(reset_n),
        .restart(state_n != state),
        .tick(tick)
    );

    assign tx_ready = (state == IDLE);
    assign finish = (state == LATCH) && tick;

    always_comb begin
        state_n = state;
        sh_n = sh;
        bits_n = bits;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = SHIFT_LO;
                sh_n = tx_data;
                bits_n = 6'(WIDTH);
            end
            SHIFT_LO: if (tick) state_n = SHIFT_HI;
            SHIFT_HI: if (tick) begin
                sh_n = sh << 1;
                bits_n = bits - 6'd1;
                state_n = (bits == 6'd1) ? LATCH : SHIFT_LO;
            end
            default: if (tick) state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the phase they describe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            sh <= '0;
            bits <= '0;
            sclk <= 1'b0;
            sdo <= 1'b0;
            latch <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            sh <= sh_n;
            bits <= bits_n;
            sclk <= (state_n == SHIFT_HI);
            sdo <= (state_n == SHIFT_LO || state_n == SHIFT_HI) && sh_n[WIDTH-1];
            latch <= (state_n == LATCH);
            done <= finish;
        end
    end

`ifdef PMOD_SHIFT_TX_READBACK_EN
    logic [WIDTH-1:0] rx_sh;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_sh <= '0;
            rx_data <= '0;
        end else begin
            if (state == SHIFT_HI && tick) rx_sh <= WIDTH'({rx_sh, sdi});
            if (finish) rx_data <= rx_sh;
        end
    end
`endif
endmodule

// File: doc/pmod_shift_tx.md
PMOD_SHIFT_TX -- requirements
Module: pmod_shift_tx

Interface
REQ-001 SHALL have parameter CLKDIV, default 6, clk cycles per serial-clock half-period, legal range 1..255.
REQ-002 SHALL have parameter WIDTH, default 8, bits per transfer, legal range 1..32.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port tx_valid  in  1  tx_data holds a word to send.
REQ-006 SHALL have port tx_data  in  WIDTH  word to shift out, MSB first.
REQ-007 SHALL have port tx_ready  out  1  block accepts a word this cycle.
REQ-008 SHALL have port sclk  out  1  serial clock to the PMOD shift register.
REQ-009 SHALL have port sdo  out  1  serial data to the PMOD.
REQ-010 SHALL have port latch  out  1  storage-register strobe to the PMOD.
REQ-011 SHALL have port done  out  1  one-cycle pulse at transfer completion.

Function
REQ-012 SHALL use FSM states IDLE, SHIFT_LO, SHIFT_HI, LATCH; tx_ready = (state==IDLE), combinational from state.
REQ-013 SHALL accept a word on any edge with tx_valid&&tx_ready, capture tx_data into a shift register, and enter SHIFT_LO; tx_data is ignored in all other cycles.
REQ-014 SHALL, in SHIFT_LO, drive sclk=0 and sdo=current MSB of the shift register for CLKDIV cycles, then go to SHIFT_HI.
REQ-015 SHALL, in SHIFT_HI, drive sclk=1 with sdo unchanged for CLKDIV cycles; at exit, shift left by one, decrement the bit count, and go to SHIFT_LO, or go to LATCH after the WIDTH-th bit.
REQ-016 SHALL, in LATCH, drive sclk=0, sdo=0 and latch=1 for CLKDIV cycles, then go to IDLE.
REQ-017 SHALL assert done for exactly the first IDLE cycle after LATCH.
REQ-018 SHALL take exactly (2*WIDTH+1)*CLKDIV cycles from the acceptance edge to the edge entering IDLE.
REQ-019 SHALL allow back-to-back transfers: acceptance in the same cycle done is high is legal, and the next word's SHIFT_LO follows with no gap.
REQ-020 SHALL register sclk, sdo and latch outputs; they SHALL never glitch.
REQ-021 SHALL let tx_valid deassert without penalty while tx_ready=0, with no effect on the word in flight.

Reset
REQ-022 SHALL, while reset_n=0 at a clk edge, set state=IDLE, sclk=0, sdo=0, latch=0, done=0, shift register=0, and counters=0.
REQ-023 SHALL, on reset mid-transfer, abandon the word with no latch pulse and no done pulse; tx_ready=1 on the first cycle after reset_n returns to 1.

Configuration
REQ-024 SHALL, with macro PMOD_SHIFT_TX_READBACK_EN defined, add port sdi (in, 1, daisy-chain return from the PMOD) and port rx_data (out, WIDTH).
REQ-025 SHALL, with that macro defined, sample sdi on the last clk cycle of each SHIFT_HI into an rx shift register, MSB first, and load rx_data when done asserts; rx_data SHALL hold until the next done and reset to 0.
REQ-026 SHALL, without that macro, have neither sdi nor rx_data ports nor rx logic; all other behaviour SHALL be identical.

Structure
REQ-027 SHALL place the FSM state enum (2 bits), CLKDIV and WIDTH default constants in shared package pmod_pkg.
REQ-028 SHALL contain one sub-module, pmod_tick_div: a CLKDIV down-counter, restarted on each state change, producing a one-cycle phase-end tick.

Verification
REQ-029 SHALL cover: CLKDIV=2, WIDTH=8, send 0xA5 -> sdo per SHIFT_LO reads 1,0,1,0,0,1,0,1; latch high 2 cycles; done at cycle 34 after acceptance.
REQ-030 SHALL cover: two words 0x01 then 0xFF, tx_valid held high -> second acceptance on the done cycle; no idle gap; two latch pulses.
REQ-031 SHALL cover: reset_n=0 during bit 3 of 0x3C -> sclk, sdo and latch go to 0 next edge; no done; tx_ready=1 after release.
REQ-032 SHALL cover: CLKDIV=1, WIDTH=1, send 0x1 -> sclk high 1 cycle, latch 1 cycle, done 3 cycles after acceptance.
REQ-033 SHALL cover, with READBACK_EN: sdi looped to sdo through an 8-bit delay model preloaded with 0x5A, send 0x00 -> rx_data=0x5A at done.
REQ-034 SHALL cover: tx_data toggled while busy -> transmitted bits match the value captured at acceptance.
